// File: rtl/clock_enable_sequencer_pkg.sv
// Shared encodings for the clock enable sequencer: command opcodes and FSM states.
package clock_enable_sequencer_pkg;

  typedef enum logic [1:0] {
    OpStop = 2'b00,
    OpRun  = 2'b01,
    OpRunN = 2'b10,
    OpStep = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StRunN = 2'b10
  } state_e;

endpackage

// File: rtl/clock_enable_sequencer_enable_divider.sv
// Enable divider: produces a pulse every divisor+1 cycles while active.
// The divisor is captured on load and the first pulse follows load immediately.
module enable_divider #(
  parameter int unsigned DIVIDE_WIDTH = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    load_i,
  input  logic                    active_i,
  input  logic [DIVIDE_WIDTH-1:0] divisor_i,
  output logic                    pulse_o
);

  logic [DIVIDE_WIDTH-1:0] div_cnt_q, div_cnt_d;
  logic [DIVIDE_WIDTH-1:0] divisor_q, divisor_d;

  assign pulse_o = (div_cnt_q == '0);

  // Next-state: reload after each pulse, otherwise count down.
  always_comb begin
    div_cnt_d = div_cnt_q;
    divisor_d = divisor_q;
    if (load_i) begin
      div_cnt_d = '0;
      divisor_d = divisor_i;
    end else if (active_i) begin
      if (div_cnt_q == '0) begin
        div_cnt_d = divisor_q;
      end else begin
        div_cnt_d = div_cnt_q - DIVIDE_WIDTH'(1);
      end
    end
  end

  // Divider state registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_cnt_q <= '0;
      divisor_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
      divisor_q <= divisor_d;
    end
  end

endmodule

// File: rtl/clock_enable_sequencer.sv
// Run/pause/single-step controller gating the clock enable of a downstream datapath.
// Commands arrive on a valid/ready handshake; enable pulses are divided and counted.
module clock_enable_sequencer
  import clock_enable_sequencer_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH  = 32,
  parameter int unsigned DIVIDE_WIDTH = 8
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [COUNT_WIDTH-1:0]  cmd_count,
  input  logic [DIVIDE_WIDTH-1:0] divisor,
  input  logic                    halt,
  output logic                    clock_enable,
  output logic                    running,
  output logic                    done,
  output logic [COUNT_WIDTH-1:0]  cycle
);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] remaining_q, remaining_d;
  logic [COUNT_WIDTH-1:0] cycle_q, cycle_d;
  logic                   done_q, done_d;
  logic                   accept;
  logic                   div_pulse;
  cmd_op_e                op;

  assign op           = cmd_op_e'(cmd_op);
  assign cmd_ready    = (state_q == StIdle);
  assign accept       = cmd_valid & cmd_ready;
  assign running      = (state_q == StRun) | (state_q == StRunN);
  assign clock_enable = running & div_pulse & ((state_q == StRun) | (remaining_q != '0));
  assign done         = done_q;
  assign cycle        = cycle_q;

  enable_divider #(
    .DIVIDE_WIDTH(DIVIDE_WIDTH)
  ) u_enable_divider (
    .clk_i    (clock),
    .rst_ni   (reset_n),
    .load_i   (accept),
    .active_i (running),
    .divisor_i(divisor),
    .pulse_o  (div_pulse)
  );

  // Next-state: command decode, run termination, pulse bookkeeping.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    cycle_d     = cycle_q;
    if (clock_enable) begin
      cycle_d = cycle_q + COUNT_WIDTH'(1);
    end
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (op)
            OpRun: state_d = StRun;
            OpRunN: begin
              // A zero count never enters the run state, so done lands one cycle after accept.
              if (cmd_count == '0) begin
                done_d = 1'b1;
              end else begin
                state_d     = StRunN;
                remaining_d = cmd_count;
              end
            end
            OpStep: begin
              state_d     = StRunN;
              remaining_d = COUNT_WIDTH'(1);
            end
            OpStop: ;
          endcase
        end
      end
      StRun: begin
        if (halt) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      StRunN: begin
        if (clock_enable) begin
          remaining_d = remaining_q - COUNT_WIDTH'(1);
        end
        if (halt || (remaining_q == '0) ||
            (clock_enable && (remaining_q == COUNT_WIDTH'(1)))) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Controller state registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      cycle_q     <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      cycle_q     <= cycle_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_clock_enable_sequencer.sv
// Scoreboard bench for clock_enable_sequencer: the driver predicts each cycle's outputs from
// the command timeline and queues them; a negedge monitor pops and compares.
module tb_clock_enable_sequencer;

  localparam int CW = 4;
  localparam int DW = 8;
  localparam int OP_STOP = 0;
  localparam int OP_RUN  = 1;
  localparam int OP_RUNN = 2;
  localparam int OP_STEP = 3;
  localparam int NO_HALT = 1000;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_op;
  logic [CW-1:0] cmd_count;
  logic [DW-1:0] divisor;
  logic          halt;
  logic          clock_enable;
  logic          running;
  logic          done;
  logic [CW-1:0] cycle;

  typedef struct {
    logic          ce;
    logic          run;
    logic          rdy;
    logic          dn;
    logic [CW-1:0] cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;
  int   model_cycle = 0;
  bit   pend_done = 1'b0;

  always #5 clock = ~clock;

  clock_enable_sequencer #(
    .COUNT_WIDTH (CW),
    .DIVIDE_WIDTH(DW)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_count   (cmd_count),
    .divisor     (divisor),
    .halt        (halt),
    .clock_enable(clock_enable),
    .running     (running),
    .done        (done),
    .cycle       (cycle)
  );

  // Monitor: one expected record per clock cycle while enabled.
  always @(negedge clock) begin
    if (mon_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_underflow at %0t: no expected record", $time);
      end else begin
        mon_e = exp_q.pop_front();
        if ({clock_enable, running, cmd_ready, done, cycle} !==
            {mon_e.ce, mon_e.run, mon_e.rdy, mon_e.dn, mon_e.cyc}) begin
          errors++;
          $display("FAIL cycle_record at %0t: got ce=%b run=%b rdy=%b done=%b cycle=%0d, expected ce=%b run=%b rdy=%b done=%b cycle=%0d",
                   $time, clock_enable, running, cmd_ready, done, cycle,
                   mon_e.ce, mon_e.run, mon_e.rdy, mon_e.dn, mon_e.cyc);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_idle();
    exp_t e;
    e.ce  = 1'b0;
    e.run = 1'b0;
    e.rdy = 1'b1;
    e.dn  = pend_done;
    e.cyc = CW'(model_cycle);
    exp_q.push_back(e);
    pend_done = 1'b0;
  endtask

  task automatic push_busy(input bit p);
    exp_t e;
    e.ce  = p;
    e.run = 1'b1;
    e.rdy = 1'b0;
    e.dn  = 1'b0;
    e.cyc = CW'(model_cycle);
    exp_q.push_back(e);
    if (p) model_cycle = (model_cycle + 1) % (1 << CW);
  endtask

  // One command: gap idle cycles, accept cycle, then busy cycles 1..last.
  // h is the busy cycle (1-based after accept) in which halt is held high.
  task automatic run_txn(input int op, input int n, input int d, input int h, input int gap);
    int last;
    int nn;
    for (int i = 0; i < gap; i++) begin
      next_cycle();
      cmd_valid = 1'b0;
      halt      = 1'($urandom % 2);
      divisor   = DW'($urandom);
      cmd_op    = 2'($urandom);
      push_idle();
    end
    next_cycle();
    cmd_valid = 1'b1;
    cmd_op    = op[1:0];
    cmd_count = n[CW-1:0];
    divisor   = d[DW-1:0];
    halt      = 1'($urandom % 2);
    push_idle();
    last = 0;
    if (op == OP_RUN) begin
      last = h;
    end else if (op == OP_STEP || (op == OP_RUNN && n > 0)) begin
      nn   = (op == OP_STEP) ? 1 : n;
      last = 1 + (nn - 1) * (d + 1);
      if (h < last) last = h;
    end
    for (int k = 1; k <= last; k++) begin
      next_cycle();
      cmd_valid = 1'($urandom % 2);
      cmd_op    = 2'($urandom);
      cmd_count = CW'($urandom);
      divisor   = DW'($urandom);
      halt      = (k == h);
      push_busy(((k - 1) % (d + 1)) == 0);
    end
    if (last > 0 || op == OP_RUNN) pend_done = 1'b1;
  endtask

  initial begin
    int op;
    int n;
    int d;
    int h;
    reset_n   = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_count = '0;
    divisor   = '0;
    halt      = 1'b0;
    #12;
    chk("reset_clock_enable", 32'(clock_enable), 0);
    chk("reset_running", 32'(running), 0);
    chk("reset_cmd_ready", 32'(cmd_ready), 1);
    chk("reset_done", 32'(done), 0);
    chk("reset_cycle", 32'(cycle), 0);
    #10;
    reset_n = 1'b1;
    mon_en  = 1'b1;

    // Directed: RUN div 0 halted after 5 pulses.
    run_txn(OP_RUN, 0, 0, 5, 1);
    // RUN_N 4 div 2, pulses at +1,+4,+7,+10.
    run_txn(OP_RUNN, 4, 2, NO_HALT, 1);
    // Back-to-back STEPs, second accepted in the done cycle.
    run_txn(OP_STEP, 0, 3, NO_HALT, 1);
    run_txn(OP_STEP, 0, 3, NO_HALT, 0);
    // RUN_N 0 then STOP.
    run_txn(OP_RUNN, 0, 1, NO_HALT, 2);
    run_txn(OP_STOP, 5, 1, NO_HALT, 1);
    run_txn(OP_STOP, 0, 0, NO_HALT, 0);
    // Bring cycle to 14, then RUN_N 3 with halt on its last pulse: wraps to 1.
    h = (14 - model_cycle + 16) % 16;
    if (h > 0) run_txn(OP_RUN, 0, 0, h, 1);
    run_txn(OP_RUNN, 3, 0, 3, 1);
    // Halt held into an immediately following RUN: ends after its first pulse.
    run_txn(OP_RUN, 0, 2, 1, 0);

    for (int t = 0; t < 150; t++) begin
      op = int'($urandom % 4);
      n  = int'($urandom % 16);
      d  = ($urandom % 4 == 0) ? int'($urandom % 7) : int'($urandom % 3);
      if (op == OP_RUN) h = 1 + int'($urandom % 12);
      else h = ($urandom % 3 == 0) ? 1 + int'($urandom % 20) : NO_HALT;
      run_txn(op, n, d, h, int'($urandom % 3));
    end

    // Trailing idle cycle to observe the final done pulse.
    next_cycle();
    cmd_valid = 1'b0;
    halt      = 1'b0;
    push_idle();
    @(negedge clock);
    #1;
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 0);

    // Asynchronous reset in the middle of a run, away from any clock edge.
    next_cycle();
    cmd_valid = 1'b1;
    cmd_op    = 2'(OP_RUN);
    divisor   = '0;
    halt      = 1'b0;
    next_cycle();
    cmd_valid = 1'b0;
    #2;
    chk("run_enable_before_reset", 32'(clock_enable), 1);
    reset_n = 1'b0;
    #1;
    chk("async_reset_clock_enable", 32'(clock_enable), 0);
    chk("async_reset_running", 32'(running), 0);
    chk("async_reset_cmd_ready", 32'(cmd_ready), 1);
    chk("async_reset_done", 32'(done), 0);
    chk("async_reset_cycle", 32'(cycle), 0);
    #10;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
